// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM states and
// instruction field offsets derived from the register/data widths.
package cpu_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LDI  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_JMP  = 4'hC,
    OP_JZ   = 4'hD,
    OP_JR   = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    STEPWAIT,
    HALT_ST
  } state_e;

  // Instruction layout, MSB first: [op][rd][ra][rb][imm]
  function automatic int rb_lsb(input int reg_aw, input int data_w);
    return data_w + 0 * reg_aw;
  endfunction

  function automatic int ra_lsb(input int reg_aw, input int data_w);
    return data_w + reg_aw;
  endfunction

  function automatic int rd_lsb(input int reg_aw, input int data_w);
    return data_w + 2 * reg_aw;
  endfunction

  function automatic int op_lsb(input int reg_aw, input int data_w);
    return data_w + 3 * reg_aw;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multicycle core; op encodes the eight
// register-register operations, carry follows the per-op borrow/shift rules.
module cpu_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              carry,
  output logic              zero
);

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      3'd0: {carry, y} = {1'b0, a} + {1'b0, b};
      3'd1: begin
        y     = a - b;
        carry = (a < b);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = ~a;
      3'd6: begin
        y     = a << 1;
        carry = a[DATA_W-1];
      end
      default: begin
        y     = a >> 1;
        carry = a[0];
      end
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle core: FETCH/DECODE/EXEC/MEM/WB sequencing, step mode, halt and a
// debug register tap. Define MULTICYCLE_CPU_TRACE_EN to add the retire trace ports.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_AW  = 4,
  parameter  int PC_W    = 8,
  localparam int INSTR_W = OPCODE_W + 3 * REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_mode,
  input  logic               step,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ready,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
`ifdef MULTICYCLE_CPU_TRACE_EN
  ,
  output logic               trace_valid,
  output logic [PC_W-1:0]    trace_pc,
  output logic [INSTR_W-1:0] trace_instr,
  output logic [DATA_W-1:0]  trace_wdata
`endif
);

  localparam int NREGS  = 1 << REG_AW;
  localparam int RB_LSB = rb_lsb(REG_AW, DATA_W);
  localparam int RA_LSB = ra_lsb(REG_AW, DATA_W);
  localparam int RD_LSB = rd_lsb(REG_AW, DATA_W);
  localparam int OP_LSB = op_lsb(REG_AW, DATA_W);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic                z_q, z_d, c_q, c_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic                req_q, req_d, we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic                halted_q, halted_d;

  opcode_e             op;
  logic [REG_AW-1:0]   rd, ra, rb;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   alu_b, alu_y;
  logic [2:0]          alu_op;
  logic                alu_c, alu_z;
  logic [PC_W-1:0]     pc_inc, imm_pc;
  state_e              retire_st;

  assign op        = opcode_e'(ir_q[OP_LSB +: OPCODE_W]);
  assign rd        = ir_q[RD_LSB +: REG_AW];
  assign ra        = ir_q[RA_LSB +: REG_AW];
  assign rb        = ir_q[RB_LSB +: REG_AW];
  assign imm       = ir_q[DATA_W-1:0];
  assign pc_inc    = pc_q + PC_W'(1);
  assign imm_pc    = PC_W'(imm);
  assign retire_st = step_mode ? STEPWAIT : FETCH;

  // ADDI and load/store address generation reuse the adder with imm as operand b.
  assign alu_b  = (op inside {OP_ADDI, OP_LD, OP_ST}) ? imm : b_q;
  assign alu_op = op[3] ? 3'd0 : op[2:0];

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a     (a_q),
    .b     (alu_b),
    .op    (alu_op),
    .y     (alu_y),
    .carry (alu_c),
    .zero  (alu_z)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves it unassigned; a missing default here would infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    z_d      = z_q;
    c_d      = c_q;
    regs_d   = regs_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    halted_d = halted_q;
    case (state_q)
      FETCH: begin
        ir_d    = imem_data;
        state_d = DECODE;
      end
      DECODE: begin
        a_d     = regs_q[ra];
        b_d     = regs_q[rb];
        state_d = EXEC;
      end
      EXEC: begin
        pc_d = pc_inc;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_ADDI: begin
            res_d   = alu_y;
            z_d     = alu_z;
            c_d     = alu_c;
            state_d = WB;
          end
          OP_LDI: begin
            res_d   = imm;
            state_d = WB;
          end
          OP_LD, OP_ST: begin
            req_d   = 1'b1;
            we_d    = (op == OP_ST);
            addr_d  = alu_y;
            wdata_d = b_q;
            state_d = MEM;
          end
          OP_JMP: begin
            pc_d    = imm_pc;
            state_d = retire_st;
          end
          OP_JZ: begin
            if (z_q) pc_d = imm_pc;
            state_d = retire_st;
          end
          OP_JR: begin
            pc_d    = PC_W'(a_q);
            state_d = retire_st;
          end
          OP_HALT: begin
            pc_d     = pc_q;
            halted_d = 1'b1;
            state_d  = HALT_ST;
          end
        endcase
      end
      MEM: begin
        if (dmem_ready) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (we_q) begin
            state_d = retire_st;
          end else begin
            res_d   = dmem_rdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        regs_d[rd] = res_q;
        state_d    = retire_st;
      end
      STEPWAIT: if (step) state_d = FETCH;
      HALT_ST:  ;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
      // NOTE: the register file is architecturally zero after reset, so every entry is cleared; that keeps it out of RAM macros.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge _d values regardless of statement order.
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      z_q      <= z_d;
      c_q      <= c_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      halted_q <= halted_d;
      regs_q   <= regs_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dbg_data   = regs_q[dbg_sel];

`ifdef MULTICYCLE_CPU_TRACE_EN
  logic               trace_valid_q, trace_valid_d;
  logic [PC_W-1:0]    trace_pc_q, ipc_q, ipc_d;
  logic [INSTR_W-1:0] trace_instr_q;
  logic [DATA_W-1:0]  trace_wdata_q, trace_wdata_d;

  // pc has already advanced by retirement, so the fetch address is kept separately.
  assign ipc_d = (state_q == FETCH) ? pc_q : ipc_q;

  always_comb begin
    trace_valid_d = 1'b0;
    trace_wdata_d = '0;
    case (state_q)
      EXEC: trace_valid_d = (op inside {OP_JMP, OP_JZ, OP_JR, OP_HALT});
      MEM:  trace_valid_d = dmem_ready && we_q;
      WB: begin
        trace_valid_d = 1'b1;
        trace_wdata_d = res_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ipc_q         <= '0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_instr_q <= '0;
      trace_wdata_q <= '0;
    end else begin
      ipc_q         <= ipc_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= ipc_q;
      trace_instr_q <= ir_q;
      trace_wdata_q <= trace_wdata_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_instr = trace_instr_q;
  assign trace_wdata = trace_wdata_q;
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: ALU vector table plus hand-written
// sequences for memory wait states, step mode, async reset in MEM and pc wrap.
module tb_multicycle_cpu;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, step_mode, step;
  logic [7:0]  imem_addr;
  logic [23:0] imem_data;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  pc;
  logic        halted;
  logic [3:0]  dbg_sel;
  logic [7:0]  dbg_data;
`ifdef MULTICYCLE_CPU_TRACE_EN
  logic        trace_valid;
  logic [7:0]  trace_pc, trace_wdata;
  logic [23:0] trace_instr;
`endif

  multicycle_cpu dut (
    .clk        (clk),
    .rst        (rst),
    .step_mode  (step_mode),
    .step       (step),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .halted     (halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
`ifdef MULTICYCLE_CPU_TRACE_EN
    ,
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_instr (trace_instr),
    .trace_wdata (trace_wdata)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [23:0] HALT_I = 24'hF00000;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [23:0] enc(input opcode_e op, input logic [3:0] rd,
                                      input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [7:0] imm);
    return {op, rd, ra, rb, imm};
  endfunction

  // Instruction ROM and data RAM models
  logic [23:0] imem [256];
  logic [7:0]  dmem [256];
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic        spurious = 1'b0;

  assign imem_data  = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  assign dmem_ready = (dmem_req && (wcnt == wait_cycles)) || spurious;

  always @(posedge clk) begin
    if (dmem_req && !dmem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  // Memory scoreboard: expected accesses pushed by the test, popped on completion
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } mem_exp_t;
  mem_exp_t sb[$];

  int         req_run = 0;
  logic [7:0] a0, w0;
  bit         chk_drop = 1'b0;

  always @(negedge clk) begin
    mem_exp_t e;
    if (chk_drop) begin
      check("req_drop", {31'b0, dmem_req}, 32'd0);
      chk_drop = 1'b0;
    end
    if (rst || !dmem_req) begin
      req_run = 0;
    end else begin
      req_run++;
      if (req_run == 1) begin
        a0 = dmem_addr;
        w0 = dmem_wdata;
      end
      if (dmem_ready) begin
        check("req_len", req_run, wait_cycles + 1);
        check("addr_stable", {24'b0, dmem_addr}, {24'b0, a0});
        check("wdata_stable", {24'b0, dmem_wdata}, {24'b0, w0});
        if (sb.size() == 0) begin
          check("sb_unexpected_access", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("mem_we", {31'b0, dmem_we}, {31'b0, e.we});
          check("mem_addr", {24'b0, dmem_addr}, {24'b0, e.addr});
          if (e.we) check("mem_wdata", {24'b0, dmem_wdata}, {24'b0, e.data});
        end
        chk_drop = 1'b1;
      end
    end
  end

`ifdef MULTICYCLE_CPU_TRACE_EN
  typedef struct {
    logic [7:0]  pc;
    logic [23:0] instr;
    logic [7:0]  wd;
  } tr_exp_t;
  tr_exp_t tq[$];
  bit      trace_on = 1'b0;

  always @(negedge clk) begin
    tr_exp_t t;
    if (trace_on && trace_valid) begin
      if (tq.size() == 0) begin
        check("trace_extra_pulse", 32'd1, 32'd0);
      end else begin
        t = tq.pop_front();
        check("trace_pc", {24'b0, trace_pc}, {24'b0, t.pc});
        check("trace_instr", {8'b0, trace_instr}, {8'b0, t.instr});
        check("trace_wdata", {24'b0, trace_wdata}, {24'b0, t.wd});
      end
    end
  end
`endif

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = HALT_I;
  endtask

  task automatic get_reg(input int idx, output logic [7:0] v);
    dbg_sel = idx[3:0];
    #1;
    v = dbg_data;
  endtask

  task automatic check_regs_zero(input string name);
    bit ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dbg_sel = i[3:0];
      #0.1;
      if (dbg_data !== 8'h00) ok = 1'b0;
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (chk) begin
      check("rst_pc", {24'b0, pc}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_req", {31'b0, dmem_req}, 32'd0);
      check("rst_we", {31'b0, dmem_we}, 32'd0);
      check("rst_flags", {30'b0, dut.z_q, dut.c_q}, 32'd0);
      check_regs_zero("rst_regs");
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts clock edges after reset release until halted; timeout fails the check
  task automatic run_until_halt(input string name, input int budget, input int exp_cyc);
    int cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_halted"}, {31'b0, halted}, 32'd1);
    if (exp_cyc > 0) check({name, "_cycles"}, cyc, exp_cyc);
  endtask

  task automatic wait_cycles_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_step();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  typedef struct {
    opcode_e    op;
    logic [7:0] a, b, y;
    logic       z, c;
  } alu_vec_t;
  alu_vec_t vecs[11];

  initial begin
    logic [7:0] v;
    int         cyc;

    rst = 1'b1; step_mode = 1'b0; step = 1'b0; dbg_sel = '0;

    vecs[0]  = '{OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1};
    vecs[1]  = '{OP_ADD, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
    vecs[3]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[5]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
    vecs[6]  = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{OP_NOT, 8'h0F, 8'h55, 8'hF0, 1'b0, 1'b0};
    vecs[8]  = '{OP_SHL, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1};
    vecs[9]  = '{OP_SHR, 8'h81, 8'h00, 8'h40, 1'b0, 1'b1};
    vecs[10] = '{OP_SHR, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1};

    // Test 1: basic program, latency 4+4+4+3; spurious ready with no request is ignored
    clear_prog();
    imem[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 8'd5);
    imem[1] = enc(OP_LDI, 4'd2, 4'd0, 4'd0, 8'd3);
    imem[2] = enc(OP_ADD, 4'd3, 4'd1, 4'd2, 8'd0);
    imem[3] = HALT_I;
`ifdef MULTICYCLE_CPU_TRACE_EN
    tq.push_back('{8'd0, imem[0], 8'd5});
    tq.push_back('{8'd1, imem[1], 8'd3});
    tq.push_back('{8'd2, imem[2], 8'd8});
    tq.push_back('{8'd3, imem[3], 8'd0});
    trace_on = 1'b1;
`endif
    spurious = 1'b1;
    do_reset(1'b1);
    run_until_halt("t1", 100, 15);
    spurious = 1'b0;
    get_reg(3, v);
    check("t1_r3", {24'b0, v}, 32'd8);
    check("t1_flags", {30'b0, dut.z_q, dut.c_q}, 32'd0);
    check("t1_pc", {24'b0, pc}, 32'd3);
    wait_cycles_n(3);
    check("t1_pc_frozen", {24'b0, pc}, 32'd3);
`ifdef MULTICYCLE_CPU_TRACE_EN
    trace_on = 1'b0;
    check("t1_trace_count", tq.size(), 32'd0);
`endif

    // ALU vector table: result observed through a store and the debug tap
    for (int i = 0; i < 11; i++) begin
      clear_prog();
      imem[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, vecs[i].a);
      imem[1] = enc(OP_LDI, 4'd2, 4'd0, 4'd0, vecs[i].b);
      imem[2] = enc(vecs[i].op, 4'd3, 4'd1, 4'd2, 8'd0);
      imem[3] = enc(OP_ST, 4'd0, 4'd0, 4'd3, 8'h40);
      wait_cycles = 0;
      sb.push_back('{1'b1, 8'h40, vecs[i].y});
      do_reset(1'b0);
      run_until_halt($sformatf("alu%0d", i), 100, 19);
      get_reg(3, v);
      check($sformatf("alu%0d_y", i), {24'b0, v}, {24'b0, vecs[i].y});
      check($sformatf("alu%0d_zc", i), {30'b0, dut.z_q, dut.c_q}, {30'b0, vecs[i].z, vecs[i].c});
      check($sformatf("alu%0d_sb", i), sb.size(), 32'd0);
    end

    // Test 2: ADDI wrap sets Z and C; taken JZ lands at 0x10 after 4+4+3 cycles
    clear_prog();
    imem[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 8'hFF);
    imem[1] = enc(OP_ADDI, 4'd2, 4'd1, 4'd0, 8'h01);
    imem[2] = enc(OP_JZ, 4'd0, 4'd0, 4'd0, 8'h10);
    do_reset(1'b1);
    cyc = 0;
    while (pc != 8'h10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t2_jz_cycles", cyc, 32'd11);
    run_until_halt("t2", 100, 0);
    get_reg(2, v);
    check("t2_r2", {24'b0, v}, 32'd0);
    check("t2_flags", {30'b0, dut.z_q, dut.c_q}, 32'd3);
    check("t2_pc", {24'b0, pc}, 32'h10);

    // Test 3: store then load at 0x20 with 3 wait cycles each
    clear_prog();
    imem[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 8'h10);
    imem[1] = enc(OP_LDI, 4'd2, 4'd0, 4'd0, 8'h5A);
    imem[2] = enc(OP_ST, 4'd0, 4'd1, 4'd2, 8'h10);
    imem[3] = enc(OP_LD, 4'd3, 4'd1, 4'd0, 8'h10);
    wait_cycles = 3;
    sb.push_back('{1'b1, 8'h20, 8'h5A});
    sb.push_back('{1'b0, 8'h20, 8'h00});
    do_reset(1'b0);
    run_until_halt("t3", 200, 26);
    get_reg(3, v);
    check("t3_ld_value", {24'b0, v}, 32'h5A);
    check("t3_sb", sb.size(), 32'd0);
    wait_cycles = 0;

    // Test 4: step mode, one retirement per pulse, pulses outside STEPWAIT ignored
    clear_prog();
    imem[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 8'd1);
    for (int i = 1; i < 6; i++) imem[i] = enc(OP_ADDI, 4'd1, 4'd1, 4'd0, 8'd1);
    step_mode = 1'b1;
    do_reset(1'b0);
    wait_cycles_n(20);
    check("t4_pc_wait", {24'b0, pc}, 32'd1);
    get_reg(1, v);
    check("t4_r1_wait", {24'b0, v}, 32'd1);
    pulse_step();
    wait_cycles_n(20);
    check("t4_pc_step1", {24'b0, pc}, 32'd2);
    pulse_step();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_cycles_n(20);
    check("t4_pc_ignored_pulse", {24'b0, pc}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      wait_cycles_n(12);
      check($sformatf("t4_pc_pulse%0d", i), {24'b0, pc}, 4 + i);
    end
    get_reg(1, v);
    check("t4_r1", {24'b0, v}, 32'd6);
    step_mode = 1'b0;
    pulse_step();
    run_until_halt("t4", 50, 0);

    // Test 5: async reset while a store waits in MEM
    clear_prog();
    imem[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 8'd7);
    imem[1] = enc(OP_ST, 4'd0, 4'd0, 4'd1, 8'h20);
    wait_cycles = 50;
    do_reset(1'b0);
    cyc = 0;
    while (!dmem_req && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_req_seen", {31'b0, dmem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_req_async", {31'b0, dmem_req}, 32'd0);
    check("t5_we_async", {31'b0, dmem_we}, 32'd0);
    check("t5_pc", {24'b0, pc}, 32'd0);
    check_regs_zero("t5_regs");
    wait_cycles = 0;
    sb.push_back('{1'b1, 8'h20, 8'd7});
    @(negedge clk);
    rst = 1'b0;
    run_until_halt("t5_restart", 100, 11);
    check("t5_sb", sb.size(), 32'd0);

    // Test 6: pc wrap 0xFF -> 0x00, JZ not taken then taken, JR
    clear_prog();
    imem[8'h00] = enc(OP_JZ, 4'd0, 4'd0, 4'd0, 8'h10);
    imem[8'h01] = enc(OP_JMP, 4'd0, 4'd0, 4'd0, 8'hFF);
    imem[8'hFF] = enc(OP_SUB, 4'd5, 4'd0, 4'd0, 8'h00);
    imem[8'h10] = enc(OP_LDI, 4'd8, 4'd0, 4'd0, 8'h30);
    imem[8'h11] = enc(OP_JR, 4'd0, 4'd8, 4'd0, 8'h00);
    do_reset(1'b0);
    cyc = 0;
    while (pc != 8'hFF && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_reach_ff", {24'b0, pc}, 32'hFF);
    cyc = 0;
    while (pc == 8'hFF && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_wrap", {24'b0, pc}, 32'h00);
    run_until_halt("t6", 100, 0);
    check("t6_pc", {24'b0, pc}, 32'h30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
